timer: RTL and testbench

TIMER -- requirements
Module: timer

---
 rtl/timer.sv | 105 ++++++++++
 tb/tb_timer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/timer.sv
// Serial-programmed interval timer: hunts for 1101 on `in`, shifts in a 4-bit delay,
// counts (delay+1) units of CYCLES_PER_UNIT clocks, then holds done until ack.
//
//   state | meaning
//   S0    | search, no pattern prefix seen
//   S1    | search, "1" seen
//   S11   | search, "11" seen
//   S110  | search, "110" seen
//   SHIFT | capturing 4 delay bits, MSB first
//   COUNT | interval running, count shows remaining units
//   DONE  | interval expired, waiting for ack
module timer #(
  parameter int CYCLES_PER_UNIT = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic [3:0] count,
  output logic       counting,
  output logic       done,
  input  logic       ack
);

  localparam int UW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
  localparam logic [UW-1:0] UNIT_LAST = UW'(CYCLES_PER_UNIT - 1);

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S110  = 3'd3,
    SHIFT = 3'd4,
    COUNT = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    delay, delay_nxt;
  logic [3:0]    digit, digit_nxt;
  logic [1:0]    nbits, nbits_nxt;
  logic [UW-1:0] unit, unit_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S0;
      delay <= 4'd0;
      digit <= 4'd0;
      nbits <= 2'd0;
      unit  <= '0;
    end else begin
      state <= state_nxt;
      delay <= delay_nxt;
      digit <= digit_nxt;
      nbits <= nbits_nxt;
      unit  <= unit_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    delay_nxt = delay;
    digit_nxt = digit;
    nbits_nxt = nbits;
    unit_nxt  = unit;
    case (state)
      S0:   if (in) state_nxt = S1;
      S1:   state_nxt = in ? S11 : S0;
      S11:  if (!in) state_nxt = S110;
      S110: begin
        if (in) begin
          state_nxt = SHIFT;
          nbits_nxt = 2'd0;
        end else begin
          state_nxt = S0;
        end
      end
      SHIFT: begin
        delay_nxt = {delay[2:0], in};
        nbits_nxt = nbits + 2'd1;
        if (nbits == 2'd3) begin
          // Load the digit straight from the completed shift so count is valid on entry.
          state_nxt = COUNT;
          digit_nxt = {delay[2:0], in};
          unit_nxt  = '0;
        end
      end
      COUNT: begin
        if (unit == UNIT_LAST) begin
          unit_nxt = '0;
          if (digit == 4'd0) state_nxt = DONE;
          else               digit_nxt = digit - 4'd1;
        end else begin
          unit_nxt = unit + UW'(1);
        end
      end
      DONE: if (ack) state_nxt = S0;
      default: state_nxt = S0;
    endcase
  end

  assign counting = (state == COUNT);
  assign done     = (state == DONE);
  assign count    = counting ? digit : 4'd0;

endmodule

// File: tb/tb_timer.sv
// Bench for timer: directed serial stimulus, a phase/arithmetic reference model checked
// every cycle, and literal expectations for interval lengths and count values.
module tb_timer;
  localparam int CPU = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] count;
  logic       counting;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int printed = 0;
  bit chk_en = 1'b0;
  bit activity = 1'b0;

  timer #(.CYCLES_PER_UNIT(CPU)) dut (
    .clk(clk), .reset(reset), .in(in), .count(count),
    .counting(counting), .done(done), .ack(ack)
  );

  always #5 clk = ~clk;

  // Reference model: 0 search, 1 shift, 2 count, 3 done
  int         phase = 0;
  logic [3:0] win = 4'd0;
  int         d = 0;
  int         nsh = 0;
  int         t = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (reset === 1'b1) begin
        phase = 0; win = 4'd0; d = 0; nsh = 0; t = 0;
      end else begin
        case (phase)
          0: begin
            win = {win[2:0], (in === 1'b1)};
            if (win == 4'b1101) begin phase = 1; nsh = 0; end
          end
          1: begin
            d = ((d << 1) | ((in === 1'b1) ? 1 : 0)) & 15;
            nsh++;
            if (nsh == 4) begin phase = 2; t = 0; end
          end
          2: begin
            t++;
            if (t == (d + 1) * CPU) phase = 3;
          end
          default: if (ack === 1'b1) begin phase = 0; win = 4'd0; end
        endcase
      end
    end
  end

  initial begin
    int exp_cnt;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        exp_cnt = (phase == 2) ? d - t / CPU : 0;
        vectors++;
        if (count !== exp_cnt[3:0] || counting !== (phase == 2) || done !== (phase == 3)) begin
          miscompares++;
          if (printed < 20) begin
            printed++;
            $display("FAIL model t=%0t count=%0d want %0d counting=%0b want %0b done=%0b want %0b",
                     $time, count, exp_cnt, counting, (phase == 2), done, (phase == 3));
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic i, input logic a);
    reset = r; in = i; ack = a;
    @(posedge clk);
    #1;
  endtask

  function automatic logic rand_x();
    case ($urandom_range(0, 2))
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'bx;
    endcase
  endfunction

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      step(1'b0, bits[k], 1'b0);
      activity = activity | (counting === 1'b1) | (done === 1'b1);
    end
  endtask

  task automatic measure(input string nm, input int exp_len, input int exp_first);
    int len;
    logic [3:0] first, last;
    len = 0; first = 4'd0; last = 4'hf;
    while (counting === 1'b1 && len < 2000) begin
      if (len == 0) first = count;
      last = count;
      len++;
      step(1'b0, rand_x(), rand_x());
    end
    check({nm, " length"}, len, exp_len);
    check({nm, " first count"}, first, exp_first);
    check({nm, " last count"}, last, 0);
    check({nm, " done after"}, done, 1);
    check({nm, " count idle"}, count, 0);
  endtask

  initial begin
    int n;
    step(1'b1, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    check("reset count", count, 0);
    check("reset counting", counting, 0);
    check("reset done", done, 0);

    send_bits(16'b0100_1101_0001, 12);
    check("d1 counting on entry", counting, 1);
    measure("delay1", 100, 1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0);
      check("done holds without ack", done, 1);
    end
    step(1'b0, 1'b0, 1'b1);
    check("done cleared by ack", done, 0);

    send_bits(16'b0101_1101_1110, 12);
    measure("delay14", 750, 14);
    step(1'b1, 1'b0, 1'b0);
    check("reset in DONE", done, 0);

    activity = 1'b0;
    for (int r = 0; r < 8; r++) send_bits(16'b1100_1001_0110_0, 13);
    check("near-miss activity", activity, 0);

    send_bits(16'b1101_0111, 8);
    n = 0;
    while (count !== 4'd5 && n < 500) begin
      step(1'b0, rand_x(), rand_x());
      n++;
    end
    check("reached count 5", count, 5);
    step(1'b1, 1'b1, 1'b1);
    check("reset mid-count count", count, 0);
    check("reset mid-count counting", counting, 0);
    check("reset mid-count done", done, 0);
    send_bits(16'b1101_0000, 8);
    measure("delay0", 50, 0);

    step(1'b0, 1'b1, 1'b1);
    check("ack with in=1", done, 0);
    activity = 1'b0;
    send_bits(16'b10_1000, 6);
    check("ack-edge bit ignored", activity, 0);

    send_bits(16'b11_0111, 6);
    step(1'b1, 1'b0, 1'b0);
    send_bits(16'b1101_0010, 8);
    measure("reset mid-shift", 150, 2);
    step(1'b0, 1'b0, 1'b1);
    check("final ack", done, 0);

    step(1'b0, 1'b0, 1'b0);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, %0d miscompares so far", miscompares);
    $fatal(1, "timeout");
  end
endmodule
